// File: rtl/dcache_ctrl_if.sv
// Bundle of CPU request/response, cache array and memory port signals for the cache sequencer.
// No latency of its own; master is the controller, slave is the LSU/array/bus side.
// Backpressure: cpu side via cpu_req_ready, memory side via mem_req_ready.
interface dcache_ctrl_if;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic [31:0] cpu_req_addr;
    logic        cpu_req_we;
    logic [31:0] cpu_req_wdata;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;

    logic [31:0] cache_addr;
    logic        cache_hit;
    logic        cache_dirty;
    logic [31:0] cache_data;
    logic [31:0] cache_victim_addr;
    logic        cache_write_valid;
    logic [31:0] cache_write_data;
    logic        cache_write_dirty;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_we;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    modport master (
        input  cpu_req_valid, cpu_req_addr, cpu_req_we, cpu_req_wdata,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
        input  cache_hit, cache_dirty, cache_data, cache_victim_addr,
        output cache_addr, cache_write_valid, cache_write_data, cache_write_dirty,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
        output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata
    );

    modport slave (
        output cpu_req_valid, cpu_req_addr, cpu_req_we, cpu_req_wdata,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
        output cache_hit, cache_dirty, cache_data, cache_victim_addr,
        input  cache_addr, cache_write_valid, cache_write_data, cache_write_dirty,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata,
        input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped data cache sequencer: lookup, dirty writeback, refill, array update, load response.
// Latency: hit responds 2 cycles after accept; clean load miss 5 cycles plus memory stalls.
// Backpressure: one request in flight (cpu_req_ready only in IDLE); mem request held until mem_req_ready.
module dcache_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    dcache_ctrl_if.master        bus,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);
    typedef enum logic [2:0] {
        IDLE, LOOKUP, WB, REFILL, REFILL_WAIT, FILL, RESP
    } state_t;

    state_t      state;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [31:0] vic_addr;
    logic [31:0] vic_data;
    logic [31:0] resp_data;
    logic        resp_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            resp_vld   <= 1'b0;
            resp_data  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            resp_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cpu_req_valid) begin
                        req_addr  <= bus.cpu_req_addr;
                        req_we    <= bus.cpu_req_we;
                        req_wdata <= bus.cpu_req_wdata;
                        resp_data <= '0;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (bus.cache_hit) begin
                        hit_count <= hit_count + 1'b1;
                        if (!req_we) resp_data <= bus.cache_data;
                        resp_vld <= 1'b1;
                        state    <= RESP;
                    end else begin
                        miss_count <= miss_count + 1'b1;
                        if (bus.cache_dirty) begin
                            vic_addr <= bus.cache_victim_addr;
                            vic_data <= bus.cache_data;
                            state    <= WB;
                        end else if (req_we) begin
                            // Lines are one word, so a store miss overwrites without refilling.
                            state <= FILL;
                        end else begin
                            state <= REFILL;
                        end
                    end
                end
                WB: begin
                    if (bus.mem_req_ready) state <= req_we ? FILL : REFILL;
                end
                REFILL: begin
                    if (bus.mem_req_ready) state <= REFILL_WAIT;
                end
                REFILL_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        resp_data <= bus.mem_resp_rdata;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    resp_vld <= 1'b1;
                    state    <= RESP;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_req_ready  = (state == IDLE);
    assign bus.cpu_resp_valid = resp_vld;
    assign bus.cpu_resp_rdata = resp_data;

    assign bus.cache_addr        = (state == IDLE) ? bus.cpu_req_addr : req_addr;
    // Store hits write during LOOKUP itself; every other array write happens in FILL.
    assign bus.cache_write_valid = ((state == LOOKUP) && bus.cache_hit && req_we) || (state == FILL);
    assign bus.cache_write_data  = req_we ? req_wdata : resp_data;
    assign bus.cache_write_dirty = req_we;

    assign bus.mem_req_valid = (state == WB) || (state == REFILL);
    assign bus.mem_req_we    = (state == WB);
    assign bus.mem_req_addr  = (state == WB) ? vic_addr : req_addr;
    assign bus.mem_req_wdata = vic_data;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: behavioural array and memory models, table of directed requests,
// plus hand sequences for writeback stalls and reset during a refill.
module tb_dcache_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    always #5 clk = ~clk;

    dcache_ctrl_if bus ();

    dcache_ctrl #(.CNT_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Array model: one-word lines, index addr[9:2], tag addr[31:10], read data one cycle after address.
    bit          arr_v   [256];
    bit [21:0]   arr_tag [256];
    bit          arr_d   [256];
    bit [31:0]   arr_dat [256];
    bit [31:0]   look_addr;
    logic [7:0]  lidx;

    always @(posedge clk) begin
        look_addr <= bus.cache_addr;
        if (bus.cache_write_valid === 1'b1) begin
            arr_v  [bus.cache_addr[9:2]] <= 1'b1;
            arr_tag[bus.cache_addr[9:2]] <= bus.cache_addr[31:10];
            arr_d  [bus.cache_addr[9:2]] <= bus.cache_write_dirty;
            arr_dat[bus.cache_addr[9:2]] <= bus.cache_write_data;
        end
    end

    assign lidx                  = look_addr[9:2];
    assign bus.cache_hit         = arr_v[lidx] && (arr_tag[lidx] == look_addr[31:10]);
    assign bus.cache_dirty       = arr_v[lidx] && arr_d[lidx];
    assign bus.cache_data        = arr_dat[lidx];
    assign bus.cache_victim_addr = {arr_tag[lidx], lidx, 2'b00};

    // Memory model: acts on the falling edge, logs every accepted request.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    mreq_t       mem_log [$];
    logic [31:0] mem_arr [int unsigned];
    int          stall_left = 0;
    int          stall_seen = 0;
    int          stall_bad  = 0;
    int          resp_delay = 0;
    int          resp_wait  = 0;
    bit          resp_pend  = 1'b0;
    logic [31:0] resp_dat;
    mreq_t       snap;

    initial begin
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_resp_valid = 1'b0;
            if (resp_pend) begin
                if (resp_wait == 0) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_rdata = resp_dat;
                    resp_pend          = 1'b0;
                end else begin
                    resp_wait--;
                end
            end
            bus.mem_req_ready = (stall_left == 0);
            if (bus.mem_req_valid === 1'b1 && rst === 1'b0) begin
                if (!bus.mem_req_ready) begin
                    if (stall_seen == 0) begin
                        snap = '{bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata};
                    end else if ({bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata}
                                 !== {snap.we, snap.addr, snap.wdata}) begin
                        stall_bad++;
                    end
                    stall_seen++;
                    stall_left--;
                end else begin
                    mem_log.push_back('{bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata});
                    if (bus.mem_req_we) begin
                        mem_arr[bus.mem_req_addr] = bus.mem_req_wdata;
                    end else begin
                        resp_pend = 1'b1;
                        resp_wait = resp_delay;
                        resp_dat  = mem_arr.exists(bus.mem_req_addr) ? mem_arr[bus.mem_req_addr]
                                                                     : (bus.mem_req_addr ^ 32'hA5A5_0000);
                    end
                end
            end
        end
    end

    // Issues one request and follows it to its response, sampling 1 time unit after each rising edge.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output int wr_cnt,
                          output logic wr_dirty, output logic [31:0] wr_data, output int rdy_bad);
        @(posedge clk); #1;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_we    = we;
        bus.cpu_req_addr  = addr;
        bus.cpu_req_wdata = wdata;
        @(posedge clk); #1;
        bus.cpu_req_valid = 1'b0;
        lat      = 1;
        wr_cnt   = 0;
        wr_dirty = 1'bx;
        wr_data  = 'x;
        rdy_bad  = 0;
        while (bus.cpu_resp_valid !== 1'b1 && lat < 60) begin
            if (bus.cache_write_valid === 1'b1) begin
                wr_cnt++;
                wr_dirty = bus.cache_write_dirty;
                wr_data  = bus.cache_write_data;
            end
            if (bus.cpu_req_ready !== 1'b0) rdy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        rdata = bus.cpu_resp_rdata;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        int          n_wb;
        logic [31:0] wb_addr;
        logic [31:0] wb_data;
        int          n_rd;
        logic [31:0] rd_addr;
        int          n_wr;
        logic        wr_dirty;
        logic [31:0] wr_data;
        int          hits;
        int          misses;
    } vec_t;

    vec_t vecs [8];

    int          lat, wr_cnt, rdy_bad, n0, nwb, nrd, cnt_wr, cnt_resp, cnt_mreq;
    logic [31:0] rdata, wr_data, wb_addr, wb_data, rd_addr;
    logic        wr_dirty;

    task automatic scan_log(input int from, output int n_w, output logic [31:0] w_addr,
                            output logic [31:0] w_data, output int n_r, output logic [31:0] r_addr);
        n_w = 0; n_r = 0; w_addr = 'x; w_data = 'x; r_addr = 'x;
        for (int j = from; j < mem_log.size(); j++) begin
            if (mem_log[j].we) begin
                if (n_w == 0) begin w_addr = mem_log[j].addr; w_data = mem_log[j].wdata; end
                n_w++;
            end else begin
                if (n_r == 0) r_addr = mem_log[j].addr;
                n_r++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            we    addr      wdata         lat rdata         wb wb_addr   wb_data       rd rd_addr  wr dty wr_data       h  m
        vecs[0] = '{1'b0, 32'h100, 32'h0,          5, 32'hDEADBEEF, 0, 32'h0,   32'h0,         1, 32'h100, 1, 1'b0, 32'hDEADBEEF, 0, 1};
        vecs[1] = '{1'b0, 32'h100, 32'h0,          2, 32'hDEADBEEF, 0, 32'h0,   32'h0,         0, 32'h0,   0, 1'b0, 32'h0,        1, 1};
        vecs[2] = '{1'b1, 32'h100, 32'h55,         2, 32'h0,        0, 32'h0,   32'h0,         0, 32'h0,   1, 1'b1, 32'h55,       2, 1};
        vecs[3] = '{1'b0, 32'h500, 32'h0,          6, 32'h12345678, 1, 32'h100, 32'h55,        1, 32'h500, 1, 1'b0, 32'h12345678, 2, 2};
        vecs[4] = '{1'b1, 32'h204, 32'hCAFE0001,   3, 32'h0,        0, 32'h0,   32'h0,         0, 32'h0,   1, 1'b1, 32'hCAFE0001, 2, 3};
        vecs[5] = '{1'b0, 32'h204, 32'h0,          2, 32'hCAFE0001, 0, 32'h0,   32'h0,         0, 32'h0,   0, 1'b0, 32'h0,        3, 3};
        vecs[6] = '{1'b1, 32'h604, 32'h77,         4, 32'h0,        1, 32'h204, 32'hCAFE0001,  0, 32'h0,   1, 1'b1, 32'h77,       3, 4};
        vecs[7] = '{1'b0, 32'h604, 32'h0,          2, 32'h77,       0, 32'h0,   32'h0,         0, 32'h0,   0, 1'b0, 32'h0,        4, 4};

        mem_arr[32'h100] = 32'hDEADBEEF;
        mem_arr[32'h500] = 32'h12345678;

        rst               = 1'b1;
        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_we    = 1'b0;
        bus.cpu_req_addr  = '0;
        bus.cpu_req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",   bus.cpu_req_ready,     1);
        check("rst_resp_valid",  bus.cpu_resp_valid,    0);
        check("rst_resp_rdata",  bus.cpu_resp_rdata,    0);
        check("rst_mem_valid",   bus.mem_req_valid,     0);
        check("rst_mem_we",      bus.mem_req_we,        0);
        check("rst_write_valid", bus.cache_write_valid, 0);
        check("rst_hit_count",   hit_count,             0);
        check("rst_miss_count",  miss_count,            0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            n0 = mem_log.size();
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rdata, wr_cnt, wr_dirty, wr_data, rdy_bad);
            scan_log(n0, nwb, wb_addr, wb_data, nrd, rd_addr);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
            check($sformatf("v%0d_busy_ready", i), rdy_bad, 0);
            check($sformatf("v%0d_num_wb", i), nwb, vecs[i].n_wb);
            if (vecs[i].n_wb > 0) begin
                check($sformatf("v%0d_wb_addr", i), wb_addr, vecs[i].wb_addr);
                check($sformatf("v%0d_wb_data", i), wb_data, vecs[i].wb_data);
            end
            check($sformatf("v%0d_num_refill", i), nrd, vecs[i].n_rd);
            if (vecs[i].n_rd > 0) check($sformatf("v%0d_refill_addr", i), rd_addr, vecs[i].rd_addr);
            check($sformatf("v%0d_num_writes", i), wr_cnt, vecs[i].n_wr);
            if (vecs[i].n_wr > 0) begin
                check($sformatf("v%0d_wr_dirty", i), wr_dirty, vecs[i].wr_dirty);
                check($sformatf("v%0d_wr_data", i), wr_data, vecs[i].wr_data);
            end
            check($sformatf("v%0d_hit_count", i), hit_count, vecs[i].hits);
            check($sformatf("v%0d_miss_count", i), miss_count, vecs[i].misses);
        end

        // Dirty load miss with memory refusing the writeback for 5 cycles.
        stall_seen = 0;
        stall_bad  = 0;
        stall_left = 5;
        n0 = mem_log.size();
        do_req(1'b0, 32'h204, 32'h0, lat, rdata, wr_cnt, wr_dirty, wr_data, rdy_bad);
        scan_log(n0, nwb, wb_addr, wb_data, nrd, rd_addr);
        check("stall_cycles",      stall_seen, 5);
        check("stall_fields_move", stall_bad,  0);
        check("stall_latency",     lat,        11);
        check("stall_wb_addr",     wb_addr,    32'h604);
        check("stall_wb_data",     wb_data,    32'h77);
        check("stall_refill_addr", rd_addr,    32'h204);
        check("stall_rdata",       rdata,      32'hCAFE0001);
        check("stall_wr_dirty",    wr_dirty,   0);
        check("stall_miss_count",  miss_count, 5);

        // Reset while waiting for refill data; the late response must be ignored.
        resp_delay = 3;
        n0 = mem_log.size();
        @(posedge clk); #1;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_we    = 1'b0;
        bus.cpu_req_addr  = 32'h800;
        @(posedge clk); #1;
        bus.cpu_req_valid = 1'b0;
        lat = 0;
        while (mem_log.size() == n0 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rstw_refill_issued", mem_log.size(), n0 + 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstw_mem_valid_drop", bus.mem_req_valid, 0);
        cnt_wr = 0; cnt_resp = 0; cnt_mreq = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.cache_write_valid === 1'b1) cnt_wr++;
            if (bus.cpu_resp_valid !== 1'b0) cnt_resp++;
            if (bus.mem_req_valid !== 1'b0) cnt_mreq++;
            @(posedge clk); #1;
        end
        resp_delay = 0;
        check("rstw_array_writes", cnt_wr,            0);
        check("rstw_cpu_resps",    cnt_resp,          0);
        check("rstw_mem_reqs",     cnt_mreq,          0);
        check("rstw_req_ready",    bus.cpu_req_ready, 1);
        check("rstw_hit_count",    hit_count,         0);
        check("rstw_miss_count",   miss_count,        0);

        do_req(1'b0, 32'h204, 32'h0, lat, rdata, wr_cnt, wr_dirty, wr_data, rdy_bad);
        check("post_rst_latency",   lat,       2);
        check("post_rst_rdata",     rdata,     32'hCAFE0001);
        check("post_rst_hit_count", hit_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
